// File: rtl/zrc_hist_pkg.sv
// Shared definitions for the histogram statistics stage: default widths,
// FSM state encoding and the saturation limit of a bin counter.
package zrc_hist_pkg;

  localparam int HIST_DW_DEF = 14;  // pixel width
  localparam int HIST_AW_DEF = 14;  // bin address width
  localparam int HIST_CW_DEF = 12;  // bin count width
  localparam int GAP_CYC_DEF = 8;   // idle cycles between the two readout passes

  // All-ones value of a w-bit counter (also correct for w == 32).
  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam logic [HIST_CW_DEF-1:0] SAT_MAX = HIST_CW_DEF'(sat_max(HIST_CW_DEF));

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCUM,
    ST_PASS1,
    ST_GAP,
    ST_PASS2
  } hist_state_t;

endpackage

// File: rtl/zrc_hist_ram.sv
// Simple dual-port bin RAM: one write port, one read port with a registered
// 1-cycle read. The array carries no reset so it maps onto block RAM.
module zrc_hist_ram #(
  parameter int AW = 14,
  parameter int DW = 12
) (
  input  logic          i_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_reg [0:(1<<AW)-1];
  logic [DW-1:0] rdata_reg;

  // Write port.
  always_ff @(posedge i_clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Registered read port; a same-cycle write to raddr returns the old value.
  always_ff @(posedge i_clk) begin
    rdata_reg <= mem_reg[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/zrc_hist_stat.sv
// Histogram statistics stage: accumulates one field of pixel values into a
// saturating bin RAM, then in blanking streams every bin twice (threshold
// pass, then cumulative pass that also clears each bin behind itself).
module zrc_hist_stat
  import zrc_hist_pkg::*;
#(
  parameter int DW          = HIST_DW_DEF,
  parameter int HIST_RAM_AW = HIST_AW_DEF,
  parameter int HIST_RAM_DW = HIST_CW_DEF,
  parameter int GAP_CYC     = GAP_CYC_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_field_vld,
  input  logic                   i_line_vld,
  input  logic [DW-1:0]          i_img_data,
  input  logic                   i_freeze,
  output logic                   o_hist_wr_field_vld,
  output logic                   o_hist_wr_line_vld,
  output logic [HIST_RAM_DW-1:0] o_hist_wr_data,
  output logic                   o_hist_rd_vld,
  output logic [HIST_RAM_DW-1:0] o_hist_rd_data,
  output logic                   o_busy,
  output logic [7:0]             o_skip_cnt
);

  localparam int NBINS = 1 << HIST_RAM_AW;
  localparam int CW    = HIST_RAM_AW + 1;  // wide enough to hold NBINS itself

  localparam logic [CW-1:0] LAST_ADDR  = CW'(NBINS - 1);
  localparam logic [CW-1:0] CLEAR_TAIL = CW'(NBINS);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2);
  localparam logic [HIST_RAM_DW-1:0] CNT_MAX = HIST_RAM_DW'(sat_max(HIST_RAM_DW));

  // Upper pixel bits do not select a bin.
  generate
    if (DW > HIST_RAM_AW) begin : g_hi_bits
      logic unused_hi_bits;
      assign unused_hi_bits = ^i_img_data[DW-1:HIST_RAM_AW];
    end
  endgenerate

  hist_state_t state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic field_d_reg;
  logic [7:0] skip_cnt_reg;

  // Accumulate pipeline: stage-1 address plus the write made one cycle ago,
  // which the registered read cannot see yet.
  logic                   acc_vld_reg;
  logic [HIST_RAM_AW-1:0] acc_addr_reg;
  logic                   fwd_vld_reg;
  logic [HIST_RAM_AW-1:0] fwd_addr_reg;
  logic [HIST_RAM_DW-1:0] fwd_data_reg;

  // Readout pipeline: read issued last cycle, data now on the RAM output.
  logic                   rs_vld_reg;
  logic                   rs_pass2_reg;
  logic [HIST_RAM_AW-1:0] rs_addr_reg;

  logic                   wr_field_vld_reg;
  logic                   wr_line_vld_reg;
  logic [HIST_RAM_DW-1:0] wr_data_reg;
  logic                   rd_vld_reg;
  logic [HIST_RAM_DW-1:0] rd_data_reg;

  logic                   field_rise;
  logic                   field_fall;
  logic                   pix_accept;
  logic [HIST_RAM_AW-1:0] pix_addr;
  logic                   rd_issue;
  logic                   rd_is_p2;
  logic                   init_we;
  logic                   ram_we;
  logic [HIST_RAM_AW-1:0] ram_waddr;
  logic [HIST_RAM_DW-1:0] ram_wdata;
  logic [HIST_RAM_AW-1:0] ram_raddr;
  logic [HIST_RAM_DW-1:0] ram_rdata;
  logic [HIST_RAM_DW-1:0] acc_old;
  logic [HIST_RAM_DW-1:0] acc_new;

  assign field_rise = i_field_vld & ~field_d_reg;
  assign field_fall = ~i_field_vld & field_d_reg;
  assign pix_addr   = i_img_data[HIST_RAM_AW-1:0];

  // A pixel arriving on the very cycle an unfrozen field opens is kept, so
  // the field needs no lead-in before its first pixel.
  assign pix_accept = i_line_vld &
                      (((state_reg == ST_ACCUM) & (cnt_reg == '0)) |
                       ((state_reg == ST_IDLE) & field_rise & ~i_freeze));

  zrc_hist_ram #(
    .AW (HIST_RAM_AW),
    .DW (HIST_RAM_DW)
  ) u_ram (
    .i_clk (i_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // State and shared counter (INIT address, drain, readout address, gap).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state, counter and which RAM activity each state drives.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rd_issue   = 1'b0;
    rd_is_p2   = 1'b0;
    init_we    = 1'b0;
    case (state_reg)
      ST_INIT: begin
        init_we = 1'b1;
        if (cnt_reg == LAST_ADDR) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_IDLE: begin
        if (field_rise && !i_freeze) begin
          state_next = ST_ACCUM;
          cnt_next   = '0;
        end
      end
      ST_ACCUM: begin
        // cnt 0: counting pixels; 1..2: letting the last write land.
        if (cnt_reg == '0) begin
          if (field_fall) begin
            cnt_next = CW'(1);
          end
        end else if (cnt_reg == DRAIN_LAST) begin
          state_next = ST_PASS1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_PASS1: begin
        rd_issue = 1'b1;
        if (cnt_reg == LAST_ADDR) begin
          state_next = ST_GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = ST_PASS2;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_PASS2: begin
        // The extra count lets the clear of the last bin complete here.
        if (cnt_reg == CLEAR_TAIL) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          rd_issue = 1'b1;
          rd_is_p2 = 1'b1;
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = ST_INIT;
        cnt_next   = '0;
      end
    endcase
  end

  // Read-modify-write datapath and RAM port arbitration.
  always_comb begin
    ram_raddr = rd_issue ? cnt_reg[HIST_RAM_AW-1:0] : pix_addr;
    acc_old   = (fwd_vld_reg && (fwd_addr_reg == acc_addr_reg)) ? fwd_data_reg : ram_rdata;
    acc_new   = (acc_old == CNT_MAX) ? acc_old : acc_old + HIST_RAM_DW'(1);
    ram_we    = 1'b0;
    ram_waddr = acc_addr_reg;
    ram_wdata = acc_new;
    if (init_we) begin
      ram_we    = 1'b1;
      ram_waddr = cnt_reg[HIST_RAM_AW-1:0];
      ram_wdata = '0;
    end else if (rs_vld_reg && rs_pass2_reg) begin
      ram_we    = 1'b1;
      ram_waddr = rs_addr_reg;
      ram_wdata = '0;
    end else if (acc_vld_reg) begin
      ram_we = 1'b1;
    end
  end

  // Field edge detection and count of fields that arrive while busy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      field_d_reg  <= 1'b0;
      skip_cnt_reg <= '0;
    end else begin
      field_d_reg <= i_field_vld;
      if (field_rise && (state_reg != ST_IDLE)) begin
        skip_cnt_reg <= skip_cnt_reg + 8'd1;
      end
    end
  end

  // Accumulate pipeline registers, including the one-deep forward of the
  // value just written.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_vld_reg  <= 1'b0;
      acc_addr_reg <= '0;
      fwd_vld_reg  <= 1'b0;
      fwd_addr_reg <= '0;
      fwd_data_reg <= '0;
    end else begin
      acc_vld_reg  <= pix_accept;
      acc_addr_reg <= pix_addr;
      fwd_vld_reg  <= acc_vld_reg;
      fwd_addr_reg <= acc_addr_reg;
      fwd_data_reg <= acc_new;
    end
  end

  // Readout pipeline and registered stream outputs (address to output: 2 cycles).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rs_vld_reg       <= 1'b0;
      rs_pass2_reg     <= 1'b0;
      rs_addr_reg      <= '0;
      wr_field_vld_reg <= 1'b0;
      wr_line_vld_reg  <= 1'b0;
      wr_data_reg      <= '0;
      rd_vld_reg       <= 1'b0;
      rd_data_reg      <= '0;
    end else begin
      rs_vld_reg       <= rd_issue;
      rs_pass2_reg     <= rd_is_p2;
      rs_addr_reg      <= cnt_reg[HIST_RAM_AW-1:0];
      wr_line_vld_reg  <= rs_vld_reg & ~rs_pass2_reg;
      wr_data_reg      <= (rs_vld_reg && !rs_pass2_reg) ? ram_rdata : '0;
      rd_vld_reg       <= rs_vld_reg & rs_pass2_reg;
      rd_data_reg      <= (rs_vld_reg && rs_pass2_reg) ? ram_rdata : '0;
      // Frames the pass-1 valids with one cycle of lead and one of tail.
      wr_field_vld_reg <= (state_reg == ST_PASS1) | (rs_vld_reg & ~rs_pass2_reg) | wr_line_vld_reg;
    end
  end

  assign o_hist_wr_field_vld = wr_field_vld_reg;
  assign o_hist_wr_line_vld  = wr_line_vld_reg;
  assign o_hist_wr_data      = wr_data_reg;
  assign o_hist_rd_vld       = rd_vld_reg;
  assign o_hist_rd_data      = rd_data_reg;
  assign o_busy              = (state_reg != ST_IDLE);
  assign o_skip_cnt          = skip_cnt_reg;

endmodule

// File: tb/tb_zrc_hist_stat.sv
// Randomized bench for zrc_hist_stat with a per-bin pixel-count model.
// Uses a 256-bin instance so whole-field readouts stay short.
module tb_zrc_hist_stat;

  localparam int DW  = 14;
  localparam int AW  = 8;
  localparam int CW  = 12;
  localparam int GAP = 8;
  localparam int NB  = 1 << AW;
  localparam int SAT = 4095;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_field_vld = 1'b0;
  logic          i_line_vld = 1'b0;
  logic [DW-1:0] i_img_data = '0;
  logic          i_freeze = 1'b0;
  logic          o_hist_wr_field_vld;
  logic          o_hist_wr_line_vld;
  logic [CW-1:0] o_hist_wr_data;
  logic          o_hist_rd_vld;
  logic [CW-1:0] o_hist_rd_data;
  logic          o_busy;
  logic [7:0]    o_skip_cnt;

  zrc_hist_stat #(
    .DW          (DW),
    .HIST_RAM_AW (AW),
    .HIST_RAM_DW (CW),
    .GAP_CYC     (GAP)
  ) dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_field_vld         (i_field_vld),
    .i_line_vld          (i_line_vld),
    .i_img_data          (i_img_data),
    .i_freeze            (i_freeze),
    .o_hist_wr_field_vld (o_hist_wr_field_vld),
    .o_hist_wr_line_vld  (o_hist_wr_line_vld),
    .o_hist_wr_data      (o_hist_wr_data),
    .o_hist_rd_vld       (o_hist_rd_vld),
    .o_hist_rd_data      (o_hist_rd_data),
    .o_busy              (o_busy),
    .o_skip_cnt          (o_skip_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Monitor: everything it records is owned here; the stimulus only reads it.
  int cyc = 0;
  int fv_cnt = 0;
  int viol = 0;
  int busy_cnt = 0;
  int p1_q[$];
  int p2_q[$];
  int wr_cyc_q[$];
  int rd_cyc_q[$];
  logic prev_fv = 1'b0;
  logic prev_lv = 1'b0;

  always @(negedge i_clk) begin
    cyc++;
    if (o_busy) busy_cnt++;
    if (o_hist_wr_field_vld) fv_cnt++;
    if (o_hist_wr_line_vld) begin
      p1_q.push_back(int'(o_hist_wr_data));
      wr_cyc_q.push_back(cyc);
      if (!o_hist_wr_field_vld) viol++;
    end
    if (o_hist_rd_vld) begin
      p2_q.push_back(int'(o_hist_rd_data));
      rd_cyc_q.push_back(cyc);
    end
    if (o_hist_wr_line_vld && o_hist_rd_vld) viol++;
    if (o_hist_wr_field_vld && !prev_fv && o_hist_wr_line_vld) viol++;
    if (!o_hist_wr_field_vld && prev_fv && prev_lv) viol++;
    prev_fv = o_hist_wr_field_vld;
    prev_lv = o_hist_wr_line_vld;
  end

  // Reference: raw pixel count per bin for the field now being read out.
  int cnt_m [NB];
  int exp_skip = 0;
  int field_no = 0;
  int pix_q[$];
  bit gap_en = 1'b0;
  int last_b1 = 0;
  int last_b2 = 0;

  function automatic int p1_at(input int k);
    return (last_b1 + k < p1_q.size()) ? p1_q[last_b1 + k] : -1;
  endfunction

  function automatic int p2_at(input int k);
    return (last_b2 + k < p2_q.size()) ? p2_q[last_b2 + k] : -1;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (o_busy && n < budget) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk(tag, int'(o_busy), 0);
  endtask

  task automatic drive_field(input bit freeze);
    // Pixels while idle and no field is open must be ignored.
    for (int i = 0; i < 3; i++) begin
      i_line_vld = 1'b1; i_img_data = DW'(1);
      @(posedge i_clk); #1;
    end
    i_line_vld  = 1'b0;
    i_field_vld = 1'b1;
    i_freeze    = freeze;
    @(posedge i_clk); #1;
    i_freeze = 1'b0;
    foreach (pix_q[i]) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        i_line_vld = 1'b0;
        @(posedge i_clk); #1;
      end
      i_line_vld = 1'b1;
      i_img_data = DW'(pix_q[i]);
      @(posedge i_clk); #1;
    end
    i_line_vld = 1'b0;
    @(posedge i_clk); #1;
    i_field_vld = 1'b0;
  endtask

  task automatic run_field(input bit freeze, input bit inject);
    int b1, bfv, bv, bb, bad1, bad2, e, g1, g2, gapv;
    wait_idle("pre_idle", 3 * NB + 100);
    b1 = p1_q.size(); last_b2 = p2_q.size(); last_b1 = b1;
    bfv = fv_cnt; bv = viol; bb = busy_cnt;
    drive_field(freeze);
    if (!freeze) foreach (pix_q[i]) cnt_m[pix_q[i] % NB]++;
    if (inject) begin
      int n;
      n = 0;
      while (!o_hist_wr_field_vld && n < 4 * NB) begin
        @(posedge i_clk); #1;
        n++;
      end
      chk("pass1_seen", int'(o_hist_wr_field_vld), 1);
      i_field_vld = 1'b1;
      for (int i = 0; i < 20; i++) begin
        i_line_vld = 1'b1;
        i_img_data = DW'($urandom_range(0, NB - 1));
        @(posedge i_clk); #1;
      end
      i_line_vld  = 1'b0;
      i_field_vld = 1'b0;
      exp_skip++;
    end
    repeat (5) @(posedge i_clk);
    #1;
    wait_idle("post_idle", 3 * NB + 100);
    repeat (4) @(posedge i_clk);
    #1;
    if (freeze) begin
      chk("frz_busy", busy_cnt - bb, 0);
      chk("frz_p1_len", p1_q.size() - b1, 0);
      chk("frz_p2_len", p2_q.size() - last_b2, 0);
    end else begin
      bad1 = 0; bad2 = 0;
      for (int k = 0; k < NB; k++) begin
        e = (cnt_m[k] > SAT) ? SAT : cnt_m[k];
        if (p1_at(k) != e) bad1++;
        if (p2_at(k) != e) bad2++;
      end
      chk("p1_len", p1_q.size() - b1, NB);
      chk("p2_len", p2_q.size() - last_b2, NB);
      chk("p1_bins_bad", bad1, 0);
      chk("p2_bins_bad", bad2, 0);
      chk("p1_field_vld_cycles", fv_cnt - bfv, NB + 2);
      chk("stream_protocol", viol - bv, 0);
      g1 = b1 + NB - 1;
      g2 = last_b2;
      gapv = (g1 < wr_cyc_q.size() && g2 < rd_cyc_q.size()) ? rd_cyc_q[g2] - wr_cyc_q[g1] : -1;
      chk("pass_gap", gapv, GAP + 1);
      for (int k = 0; k < NB; k++) cnt_m[k] = 0;
    end
    chk("skip_cnt", int'(o_skip_cnt), exp_skip);
    $display("field %0d: freeze=%0d pixels=%0d skip_inject=%0d p1=%0d p2=%0d skip=%0d",
             field_no, freeze, pix_q.size(), inject, p1_q.size() - b1,
             p2_q.size() - last_b2, o_skip_cnt);
    field_no++;
  endtask

  task automatic check_init(input string tag);
    int n;
    n = 0;
    chk({tag, "_busy"}, int'(o_busy), 1);
    while (o_busy && n < NB + 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk({tag, "_len"}, (n >= NB - 2 && n <= NB + 2) ? NB : n, NB);
  endtask

  task automatic fill_random(input int n);
    int v;
    pix_q.delete();
    for (int i = 0; i < n; i++) begin
      if (pix_q.size() > 0 && $urandom_range(0, 2) == 0) v = pix_q[$];
      else if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 15));
      else v = int'($urandom_range(0, 16383));
      pix_q.push_back(v);
    end
  endtask

  initial begin
    int n;
    for (int k = 0; k < NB; k++) cnt_m[k] = 0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_wr_field_vld", int'(o_hist_wr_field_vld), 0);
    chk("rst_wr_line_vld", int'(o_hist_wr_line_vld), 0);
    chk("rst_wr_data", int'(o_hist_wr_data), 0);
    chk("rst_rd_vld", int'(o_hist_rd_vld), 0);
    chk("rst_rd_data", int'(o_hist_rd_data), 0);
    chk("rst_skip", int'(o_skip_cnt), 0);
    i_rst = 1'b0;
    check_init("init");

    // Empty field.
    pix_q.delete();
    run_field(1'b0, 1'b0);

    // 100 pixels of value 5, then an empty field must read all zero.
    pix_q.delete();
    for (int i = 0; i < 100; i++) pix_q.push_back(5);
    run_field(1'b0, 1'b0);
    chk("bin5_p1", p1_at(5), 100);
    chk("bin5_p2", p2_at(5), 100);
    pix_q.delete();
    run_field(1'b0, 1'b0);

    // Back-to-back and alternating equal addresses.
    pix_q = '{3, 3, 7, 3, 7, 7};
    run_field(1'b0, 1'b0);
    chk("bin3", p1_at(3), 3);
    chk("bin7", p1_at(7), 3);

    // Saturation.
    pix_q.delete();
    for (int i = 0; i < 5000; i++) pix_q.push_back(9);
    run_field(1'b0, 1'b0);
    chk("bin9_sat_p1", p1_at(9), SAT);
    chk("bin9_sat_p2", p2_at(9), SAT);

    // Frozen field, then a normal field on the same bin.
    pix_q.delete();
    for (int i = 0; i < 50; i++) pix_q.push_back(2);
    run_field(1'b1, 1'b0);
    pix_q.delete();
    for (int i = 0; i < 10; i++) pix_q.push_back(2);
    run_field(1'b0, 1'b0);
    chk("bin2_after_freeze", p1_at(2), 10);

    // New field arriving during pass 1.
    gap_en = 1'b1;
    fill_random(200);
    run_field(1'b0, 1'b1);

    // Randomized fields with line-valid gaps.
    for (int f = 0; f < 3; f++) begin
      fill_random(150 + 100 * f);
      run_field(1'b0, 1'b0);
    end

    // Reset in the middle of pass 2.
    fill_random(150);
    wait_idle("pre_rst_idle", 3 * NB + 100);
    drive_field(1'b0);
    n = 0;
    while (!o_hist_rd_vld && n < 4 * NB) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("pass2_seen", int'(o_hist_rd_vld), 1);
    repeat (20) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    exp_skip = 0;
    chk("midrst_rd_vld", int'(o_hist_rd_vld), 0);
    chk("midrst_rd_data", int'(o_hist_rd_data), 0);
    chk("midrst_wr_line_vld", int'(o_hist_wr_line_vld), 0);
    chk("midrst_wr_field_vld", int'(o_hist_wr_field_vld), 0);
    chk("midrst_skip", int'(o_skip_cnt), exp_skip);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check_init("reinit");
    fill_random(300);
    run_field(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
